// File: rtl/la_capture_core.sv
// Logic-analyzer capture engine: prescaled sampling into a circular buffer with a pre-trigger
// window, masked level / edge / forced trigger, and oldest-first valid/ready readout.
module la_capture_core #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    parameter  int PS_W   = 32,
    localparam int AW     = $clog2(DEPTH),
    localparam int IW     = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_mrst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_arm,
    input  logic              i_abort,
    input  logic              i_force,
    input  logic [DATA_W-1:0] i_trig_mask,
    input  logic [DATA_W-1:0] i_trig_value,
    input  logic              i_edge_en,
    input  logic [IW-1:0]     i_edge_idx,
    input  logic              i_edge_rise,
    input  logic [AW:0]       i_pre_count,
    input  logic [PS_W-1:0]   i_prescale,
    output logic [2:0]        o_state,
    output logic              o_triggered,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_last,
    output logic              o_rd_trig
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_POST  = 3'd3,
        ST_FETCH = 3'd4,
        ST_READ  = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   mask_reg, mask_next;
    logic [DATA_W-1:0]   value_reg, value_next;
    logic                edge_en_reg, edge_en_next;
    logic [IW-1:0]       edge_idx_reg, edge_idx_next;
    logic                edge_rise_reg, edge_rise_next;
    logic [AW-1:0]       pre_reg, pre_next;
    logic [PS_W-1:0]     prescale_reg, prescale_next;
    logic [PS_W-1:0]     ps_cnt_reg, ps_cnt_next;
    logic [AW-1:0]       pre_cnt_reg, pre_cnt_next;
    logic [AW:0]         post_cnt_reg, post_cnt_next;
    logic [AW-1:0]       wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]       rd_idx_reg, rd_idx_next;
    logic [DATA_W-1:0]   prev_sample_reg, prev_sample_next;
    logic                prev_valid_reg, prev_valid_next;
    logic                force_pend_reg, force_pend_next;
    logic                triggered_reg, triggered_next;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data_reg;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;

    logic                capturing;
    logic                strobe;
    logic                arm_ok;
    logic [AW-1:0]       pre_clamped;
    logic [AW:0]         post_target;
    logic                cur_bit;
    logic                prev_bit;
    logic                level_hit;
    logic                edge_hit;
    logic                fire;

    assign capturing   = (state_reg == ST_PRE) || (state_reg == ST_WAIT) || (state_reg == ST_POST);
    assign strobe      = capturing && (ps_cnt_reg == prescale_reg);
    assign arm_ok      = (state_reg == ST_IDLE) && i_arm && !i_abort;
    assign pre_clamped = (i_pre_count > {1'b0, LAST_IDX}) ? LAST_IDX : i_pre_count[AW-1:0];
    assign post_target = DEPTH_W - {1'b0, pre_reg};

    // Trigger evaluation always looks at the sample being written on this strobe.
    assign cur_bit   = i_data[edge_idx_reg];
    assign prev_bit  = prev_sample_reg[edge_idx_reg];
    assign level_hit = ((i_data ^ value_reg) & mask_reg) == '0;
    assign edge_hit  = prev_valid_reg &&
                       (edge_rise_reg ? (!prev_bit && cur_bit) : (prev_bit && !cur_bit));
    assign fire      = (state_reg == ST_WAIT) && strobe &&
                       (force_pend_reg || (level_hit && (edge_hit || !edge_en_reg)));

    always_comb begin
        state_next       = state_reg;
        mask_next        = mask_reg;
        value_next       = value_reg;
        edge_en_next     = edge_en_reg;
        edge_idx_next    = edge_idx_reg;
        edge_rise_next   = edge_rise_reg;
        pre_next         = pre_reg;
        prescale_next    = prescale_reg;
        ps_cnt_next      = ps_cnt_reg;
        pre_cnt_next     = pre_cnt_reg;
        post_cnt_next    = post_cnt_reg;
        wr_ptr_next      = wr_ptr_reg;
        rd_ptr_next      = rd_ptr_reg;
        rd_idx_next      = rd_idx_reg;
        prev_sample_next = prev_sample_reg;
        prev_valid_next  = prev_valid_reg;
        force_pend_next  = force_pend_reg;
        triggered_next   = triggered_reg;
        rd_en            = 1'b0;
        rd_addr          = rd_ptr_reg;

        if (capturing) begin
            ps_cnt_next = strobe ? '0 : ps_cnt_reg + 1'b1;
            if (strobe) begin
                wr_ptr_next      = wr_ptr_reg + 1'b1;
                prev_sample_next = i_data;
                prev_valid_next  = 1'b1;
            end
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (arm_ok) begin
                    mask_next       = i_trig_mask;
                    value_next      = i_trig_value;
                    edge_en_next    = i_edge_en;
                    edge_idx_next   = i_edge_idx;
                    edge_rise_next  = i_edge_rise;
                    pre_next        = pre_clamped;
                    prescale_next   = i_prescale;
                    ps_cnt_next     = '0;
                    pre_cnt_next    = '0;
                    post_cnt_next   = '0;
                    prev_valid_next = 1'b0;
                    state_next      = (pre_clamped == '0) ? ST_WAIT : ST_PRE;
                end
            end
            ST_PRE: begin
                if (strobe) begin
                    pre_cnt_next = pre_cnt_reg + 1'b1;
                    if (pre_cnt_reg + 1'b1 == pre_reg) begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (fire) begin
                    post_cnt_next  = (AW+1)'(1);
                    triggered_next = 1'b1;
                    state_next     = (pre_reg == LAST_IDX) ? ST_FETCH : ST_POST;
                end else if (i_force) begin
                    force_pend_next = 1'b1;
                end
            end
            ST_POST: begin
                if (strobe) begin
                    post_cnt_next = post_cnt_reg + 1'b1;
                    if (post_cnt_reg + 1'b1 == post_target) begin
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // wr_ptr now addresses the oldest of the last DEPTH writes
                rd_en       = 1'b1;
                rd_addr     = wr_ptr_reg;
                rd_ptr_next = wr_ptr_reg;
                rd_idx_next = '0;
                state_next  = ST_READ;
            end
            ST_READ: begin
                if (i_rd_ready) begin
                    if (rd_idx_reg == LAST_IDX) begin
                        state_next = ST_IDLE;
                    end else begin
                        rd_en       = 1'b1;
                        rd_addr     = rd_ptr_reg + 1'b1;
                        rd_ptr_next = rd_ptr_reg + 1'b1;
                        rd_idx_next = rd_idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (i_abort) begin
            state_next = ST_IDLE;
        end
        if (state_next != ST_WAIT) begin
            force_pend_next = 1'b0;
        end
        if (state_next == ST_IDLE) begin
            triggered_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_mrst) begin
        if (i_mrst) begin
            state_reg       <= ST_IDLE;
            mask_reg        <= '0;
            value_reg       <= '0;
            edge_en_reg     <= 1'b0;
            edge_idx_reg    <= '0;
            edge_rise_reg   <= 1'b0;
            pre_reg         <= '0;
            prescale_reg    <= '0;
            ps_cnt_reg      <= '0;
            pre_cnt_reg     <= '0;
            post_cnt_reg    <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            rd_idx_reg      <= '0;
            prev_sample_reg <= '0;
            prev_valid_reg  <= 1'b0;
            force_pend_reg  <= 1'b0;
            triggered_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mask_reg        <= mask_next;
            value_reg       <= value_next;
            edge_en_reg     <= edge_en_next;
            edge_idx_reg    <= edge_idx_next;
            edge_rise_reg   <= edge_rise_next;
            pre_reg         <= pre_next;
            prescale_reg    <= prescale_next;
            ps_cnt_reg      <= ps_cnt_next;
            pre_cnt_reg     <= pre_cnt_next;
            post_cnt_reg    <= post_cnt_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            rd_idx_reg      <= rd_idx_next;
            prev_sample_reg <= prev_sample_next;
            prev_valid_reg  <= prev_valid_next;
            force_pend_reg  <= force_pend_next;
            triggered_reg   <= triggered_next;
        end
    end

    // Sample buffer: no reset so it maps onto block RAM; read port only advances on demand.
    always_ff @(posedge i_clk) begin
        if (strobe) begin
            mem[wr_ptr_reg] <= i_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign o_state     = state_reg;
    assign o_triggered = triggered_reg;
    assign o_rd_valid  = (state_reg == ST_READ);
    assign o_rd_data   = o_rd_valid ? rd_data_reg : '0;
    assign o_rd_last   = o_rd_valid && (rd_idx_reg == LAST_IDX);
    assign o_rd_trig   = o_rd_valid && (rd_idx_reg == pre_reg);

endmodule

// File: tb/tb_la_capture_core.sv
// Randomized bench for la_capture_core: a sample-schedule model predicts each captured window.
module tb_la_capture_core;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int PS_W   = 32;

    logic              clk = 1'b0;
    logic              i_mrst = 1'b1;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_arm = 1'b0;
    logic              i_abort = 1'b0;
    logic              i_force = 1'b0;
    logic [DATA_W-1:0] i_trig_mask = '0;
    logic [DATA_W-1:0] i_trig_value = '0;
    logic              i_edge_en = 1'b0;
    logic [2:0]        i_edge_idx = '0;
    logic              i_edge_rise = 1'b0;
    logic [4:0]        i_pre_count = '0;
    logic [PS_W-1:0]   i_prescale = '0;
    logic [2:0]        o_state;
    logic              o_triggered;
    logic              o_rd_valid;
    logic              i_rd_ready = 1'b0;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_last;
    logic              o_rd_trig;

    la_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PS_W(PS_W)) dut (
        .i_clk       (clk),
        .i_mrst      (i_mrst),
        .i_data      (i_data),
        .i_arm       (i_arm),
        .i_abort     (i_abort),
        .i_force     (i_force),
        .i_trig_mask (i_trig_mask),
        .i_trig_value(i_trig_value),
        .i_edge_en   (i_edge_en),
        .i_edge_idx  (i_edge_idx),
        .i_edge_rise (i_edge_rise),
        .i_pre_count (i_pre_count),
        .i_prescale  (i_prescale),
        .o_state     (o_state),
        .o_triggered (o_triggered),
        .o_rd_valid  (o_rd_valid),
        .i_rd_ready  (i_rd_ready),
        .o_rd_data   (o_rd_data),
        .o_rd_last   (o_rd_last),
        .o_rd_trig   (o_rd_trig)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cap_no  = 0;

    // hist[n] is the data value present at the n-th rising edge
    logic [7:0] hist[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         force_q[$];
    logic [7:0] ramp_val = 8'h00;
    bit         ramp_mode = 1'b1;

    int         arm_edge;
    int         cfg_pre;
    int         cfg_ps;
    logic [7:0] cfg_mask;
    logic [7:0] cfg_value;
    bit         cfg_een;
    int         cfg_idx;
    bit         cfg_rise;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        i_data = ramp_mode ? ramp_val : 8'($urandom);
        ramp_val = ramp_val + 8'd1;
        hist.push_back(i_data);
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int pre, input int ps, input logic [7:0] mask, input logic [7:0] value,
                       input bit een, input int idx, input bit rise);
        i_pre_count  = 5'(pre);
        i_prescale   = 32'(ps);
        i_trig_mask  = mask;
        i_trig_value = value;
        i_edge_en    = een;
        i_edge_idx   = 3'(idx);
        i_edge_rise  = rise;
        cfg_pre   = (pre > DEPTH - 1) ? DEPTH - 1 : pre;
        cfg_ps    = ps;
        cfg_mask  = mask;
        cfg_value = value;
        cfg_een   = een;
        cfg_idx   = idx;
        cfg_rise  = rise;
        force_q.delete();
        arm_edge = hist.size();
        i_arm = 1'b1;
        step();
        i_arm = 1'b0;
    endtask

    // Window predicted from the strobe schedule: sample k is taken at edge arm+(k+1)*(ps+1).
    function automatic bit model();
        logic [7:0] cur;
        logic [7:0] prv;
        int  t;
        int  e;
        bit  lvl;
        bit  edg;
        bit  frc;
        exp_q.delete();
        t = -1;
        prv = '0;
        for (int k = 0; t < 0; k++) begin
            e = arm_edge + (k + 1) * (cfg_ps + 1);
            if (e >= hist.size()) return 1'b0;
            cur = hist[e];
            if (k >= cfg_pre) begin
                lvl = ((cur ^ cfg_value) & cfg_mask) == 8'h00;
                edg = (k >= 1) && (cfg_rise ? (!prv[cfg_idx] && cur[cfg_idx])
                                            : (prv[cfg_idx] && !cur[cfg_idx]));
                frc = 1'b0;
                foreach (force_q[i]) begin
                    if (force_q[i] > arm_edge && (force_q[i] - arm_edge - 1) / (cfg_ps + 1) >= cfg_pre
                        && e > force_q[i]) frc = 1'b1;
                end
                if (frc || (lvl && (edg || !cfg_een))) t = k;
            end
            prv = cur;
        end
        for (int j = t - cfg_pre; j < t - cfg_pre + DEPTH; j++) begin
            e = arm_edge + (j + 1) * (cfg_ps + 1);
            if (e >= hist.size()) return 1'b0;
            exp_q.push_back(hist[e]);
        end
        return 1'b1;
    endfunction

    // Advance until o_state==target while scrambling config inputs that must be ignored.
    task automatic run_to(input logic [2:0] target, input int f1, input int f2, output bit ok);
        int rel;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (o_state == target) begin
                ok = 1'b1;
                break;
            end
            i_trig_mask  = 8'($urandom);
            i_trig_value = 8'($urandom);
            i_edge_en    = 1'($urandom);
            i_edge_idx   = 3'($urandom);
            i_edge_rise  = 1'($urandom);
            i_pre_count  = 5'($urandom);
            i_prescale   = 32'($urandom_range(0, 5));
            rel = hist.size() - arm_edge;
            i_force = (rel == f1) || (rel == f2);
            if (i_force) force_q.push_back(hist.size());
            i_arm = ($urandom_range(0, 15) == 0);
            step();
        end
        i_force = 1'b0;
        i_arm   = 1'b0;
        check("reach_state", 32'(ok), 32'd1);
    endtask

    task automatic read_window(input bit rand_ready);
        int idx;
        idx = 0;
        for (int n = 0; n < 400 && idx < DEPTH; n++) begin
            i_rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            i_arm = ($urandom_range(0, 7) == 0);
            check("rd_valid", 32'(o_rd_valid), 32'd1);
            check("rd_word", {22'd0, o_rd_trig, o_rd_last, o_rd_data},
                  {22'd0, idx == cfg_pre, idx == DEPTH - 1, exp_q[idx]});
            if (i_rd_ready) begin
                got_q.push_back(o_rd_data);
                idx++;
            end
            step();
        end
        i_rd_ready = 1'b0;
        i_arm = 1'b0;
        check("rd_count", 32'(idx), 32'(DEPTH));
        check("done_state", 32'(o_state), 32'd0);
        check("done_valid", 32'(o_rd_valid), 32'd0);
        check("done_trig", 32'(o_triggered), 32'd0);
    endtask

    task automatic capture(input string name, input bit rand_ready, input int f1, input int f2,
                           output bit ok);
        bit found;
        got_q.delete();
        run_to(3'd5, f1, f2, ok);
        if (!ok) return;
        found = model();
        check("model_trig", 32'(found), 32'd1);
        check("read_triggered", 32'(o_triggered), 32'd1);
        read_window(rand_ready);
        cap_no++;
        $display("[TB] capture %0d %s: pre=%0d ps=%0d mask=%h value=%h edge=%0d words=%0d trig_word=%h",
                 cap_no, name, cfg_pre, cfg_ps, cfg_mask, cfg_value, cfg_een, got_q.size(),
                 (got_q.size() > cfg_pre) ? got_q[cfg_pre] : 8'h00);
    endtask

    initial begin
        bit ok;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] dlt;

        repeat (3) step();
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_trig", 32'(o_triggered), 32'd0);
        check("rst_valid", 32'(o_rd_valid), 32'd0);
        check("rst_out", {21'd0, o_rd_trig, o_rd_last, o_rd_data}, 32'd0);
        i_mrst = 1'b0;
        step();

        // Ramp with level trigger on 0x20
        ramp_mode = 1'b1;
        arm(4, 0, 8'hFF, 8'h20, 1'b0, 0, 1'b1);
        capture("ramp_level", 1'b0, -1, -1, ok);
        if (ok) begin
            check("t1_first", 32'(got_q[0]), 32'h1C);
            check("t1_last", 32'(got_q[DEPTH-1]), 32'h2B);
        end

        // Same window under random backpressure
        arm(4, 0, 8'hFF, 8'h20, 1'b0, 0, 1'b1);
        capture("ramp_stall", 1'b1, -1, -1, ok);
        if (ok) begin
            check("t4_first", 32'(got_q[0]), 32'h1C);
            check("t4_trigword", 32'(got_q[4]), 32'h20);
        end

        // Rising edge on bit 3, prescale 2
        arm(5, 2, 8'h00, 8'h00, 1'b1, 3, 1'b1);
        capture("edge_rise", 1'b0, -1, -1, ok);
        if (ok) begin
            w0  = got_q[4];
            w1  = got_q[5];
            dlt = got_q[1] - got_q[0];
            check("t2_spacing", 32'(dlt), 32'd3);
            check("t2_edge", {30'd0, w0[3], w1[3]}, 32'd1);
        end

        // Pre count clamped to DEPTH-1, then pre=0 immediate trigger
        ramp_mode = 1'b0;
        arm(20, 1, 8'h03, 8'h01, 1'b0, 0, 1'b0);
        capture("pre_clamp", 1'b1, -1, -1, ok);
        arm(0, 0, 8'h00, 8'h00, 1'b0, 0, 1'b0);
        capture("pre_zero", 1'b0, -1, -1, ok);
        if (ok) check("t3_first", 32'(got_q[0]), 32'(hist[arm_edge+1]));

        // Force in PRE ignored, force in WAIT fires on the following strobe
        arm(6, 1, 8'hFF, 8'h5A, 1'b1, 2, 1'b0);
        capture("force", 1'b0, 3, 30, ok);

        // Abort in POST, then re-arm
        arm(2, 3, 8'h00, 8'h00, 1'b0, 0, 1'b1);
        run_to(3'd3, -1, -1, ok);
        check("post_triggered", 32'(o_triggered), 32'd1);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("abort_state", 32'(o_state), 32'd0);
        check("abort_trig", 32'(o_triggered), 32'd0);
        ramp_mode = 1'b1;
        arm(4, 0, 8'hFF, 8'h20, 1'b0, 0, 1'b1);
        capture("after_abort", 1'b1, -1, -1, ok);

        // Abort beats a same-cycle arm
        i_arm = 1'b1;
        i_abort = 1'b1;
        step();
        i_arm = 1'b0;
        i_abort = 1'b0;
        check("arm_abort_state", 32'(o_state), 32'd0);

        // Asynchronous reset in the middle of readout
        ramp_mode = 1'b0;
        arm(3, 0, 8'h00, 8'h00, 1'b0, 0, 1'b1);
        run_to(3'd5, -1, -1, ok);
        i_rd_ready = 1'b1;
        repeat (5) step();
        #2;
        i_mrst = 1'b1;
        #1;
        check("mrst_state", 32'(o_state), 32'd0);
        check("mrst_valid", 32'(o_rd_valid), 32'd0);
        check("mrst_trig", 32'(o_triggered), 32'd0);
        i_rd_ready = 1'b0;
        step();
        i_mrst = 1'b0;
        step();
        arm(7, 1, 8'h01, 8'h01, 1'b1, 5, 1'b0);
        capture("after_mrst", 1'b1, -1, -1, ok);

        // Randomized configurations
        for (int r = 0; r < 8; r++) begin
            ramp_mode = 1'($urandom);
            arm($urandom_range(0, 20), $urandom_range(0, 2), 8'($urandom & $urandom & $urandom),
                8'($urandom), 1'($urandom), $urandom_range(0, 7), 1'($urandom));
            capture("random", 1'($urandom), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 60) : -1,
                    -1, ok);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
